pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the single-cycle/pipelined RISC-V core. It holds the fetch PC and presents it to instruction memory through a valid/ready handshake. It resolves all six conditional branch types plus JAL/JALR internally and buffers a redirect that arrives while fetch is blocked. It replaces the fixed PC+4/branch/jump register and adds stall, flush and misaligned-target handling.

## Interface
- XLEN, 32: PC and operand width.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- TRAP_VECTOR, 32'h0000_0100: redirect target on misaligned control transfer (only used with MISALIGN_CHECK_EN).

Ports. Reset is rst, synchronous, active-high; the clock is clk.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hazard-unit hold; the PC does not advance sequentially.
- fetch_ready  in  1  inst_mem accepts the current pc this cycle.
- pc  out  XLEN  fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- ex_pc  in  XLEN  PC of the instruction being resolved.
- imm  in  XLEN  sign-extended immediate, byte offset.
- rs1_val, rs2_val  in  XLEN  register operands.
- br_en  in  1  conditional branch present.
- br_op  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Other codes are not taken.
- jump  in  2  00 none, 01 JAL, 10 JALR, 11 treated as none.
- link  out  XLEN  ex_pc+4, combinational.
- flush  out  1  a control transfer is taken this cycle, combinational.
- misalign  out  1  misaligned target detected, registered one-cycle pulse.
- bad_target  out  XLEN  last misaligned target.

## Operation
**Taken condition**
- taken = (br_en & cond(br_op)) | jump==01 | jump==10.
- Signed compares apply to BLT/BGE; unsigned compares apply to BLTU/BGEU.
- If br_en and jump are both set, the jump has priority. The branch and jump cases give the same result (taken), so priority matters only for target selection.

**Target**
- Branch/JAL target = ex_pc + imm.
- JALR target = (rs1_val + imm) & ~1.
- All sums are modulo 2^XLEN and wrap silently.

**State machine**
- RESET → RUN: one cycle after rst deasserts. pc_valid = 0 in RESET.
- RUN:
  - If taken and fetch_ready: pc ← target.
  - Else if taken and !fetch_ready: pend_pc ← target, go to PEND.
  - Else if fetch_ready & !stall: pc ← pc+4.
  - Else: hold.
- PEND:
  - pc_valid stays 1 with the old pc until the handshake completes.
  - When fetch_ready: pc ← pend_pc, go to RUN.
  - A new taken transfer in PEND overwrites pend_pc (the youngest wins).
- stall never blocks a redirect. A redirect flushes the stalled instructions.

**Reset values**
- pc = RESET_VECTOR, pc_valid = 0, state = RESET.
- pend_pc = 0, misalign = 0, bad_target = 0.
- rst mid-PEND discards the pending target.

## Timing
- flush and link are combinational, in the same cycle as the inputs.
- Redirect latency: the new pc is visible on the cycle after taken when fetch_ready = 1. Otherwise it is visible on the cycle after fetch_ready rises.
- Sequential latency: one pc+4 per accepted handshake. pc is stable while pc_valid & !fetch_ready.
- misalign pulses for exactly one cycle, aligned with pc update to TRAP_VECTOR.

## Configuration
- MISALIGN_CHECK_EN defined:
  - A taken target with target[1] = 1 asserts misalign and latches bad_target ← target.
  - The redirect goes to TRAP_VECTOR instead of the target.
  - The PEND path applies the same substitution.
- Undefined:
  - target[1:0] is forced to 00.
  - misalign and bad_target are tied to 0.

## Test plan
- Reset: rst high for 3 cycles with RESET_VECTOR = 0 → pc = 0, pc_valid = 0. One cycle after release pc_valid = 1. Then with fetch_ready = 1: pc = 0, 4, 8, 12.
- Branches: ex_pc = 0x40, imm = 0x20, BLT with rs1 = 0xFFFF_FFFF, rs2 = 1 → flush = 1, next pc = 0x60. Same operands with BLTU → flush = 0, pc+4.
- JALR: rs1 = 0x1001, imm = 0x10 → target 0x1010, link = ex_pc+4. With MISALIGN_CHECK_EN: rs1 = 0x1002, imm = 0 → misalign pulse, bad_target = 0x1002, pc = 0x100.
- Stall vs. redirect: stall = 1 holds pc = 0x20 for 3 cycles. JAL with ex_pc = 0x18, imm = 0x80 during the stall → pc = 0x98 next cycle.
- Pending redirect: fetch_ready = 0, taken to 0x200, then taken to 0x300 while still blocked → pc stays at the old value. When fetch_ready rises, pc = 0x300 (not 0x200).
- Reset mid-PEND: assert rst while PEND holds 0x300 → pc = RESET_VECTOR. No later jump to 0x300.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Holds the fetch PC and offers it to instruction memory over a valid/ready
// handshake. It resolves conditional branches, JAL and JALR, and buffers a
// redirect that arrives while fetch is blocked.
// Optional feature macro: MISALIGN_CHECK_EN. When it is defined, a taken
// target with bit 1 set is sent to TRAP_VECTOR and reported. When it is
// undefined, target[1:0] is forced to 00.
//
// Handshake: o_pc is a fetch request whenever o_pc_valid is 1. The request is
// accepted on a rising clk edge where o_pc_valid & i_fetch_ready are both 1.
// o_pc does not change while o_pc_valid & !i_fetch_ready, unless rst is
// asserted.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_fetch_ready,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pc_valid,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic            i_br_en,
  input  logic [2:0]      i_br_op,
  input  logic [1:0]      i_jump,
  output logic [XLEN-1:0] o_link,
  output logic            o_flush,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_bad_target,
  output logic [1:0]      o_state
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_pc, w_pc_n;
  logic [XLEN-1:0] r_pend_pc, w_pend_pc_n;
  logic            r_pend_bad, w_pend_bad_n;
  logic [XLEN-1:0] r_pend_raw, w_pend_raw_n;
  logic            r_misalign, w_misalign_n;
  logic [XLEN-1:0] r_bad_target, w_bad_target_n;

  logic            w_cond;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_eff_target;
  logic            w_bad;

  // Branch condition from funct3; codes not listed are never taken.
  always_comb begin
    w_cond = 1'b0;
    case (i_br_op)
      3'b000:  w_cond = (i_rs1_val == i_rs2_val);
      3'b001:  w_cond = (i_rs1_val != i_rs2_val);
      3'b100:  w_cond = ($signed(i_rs1_val) <  $signed(i_rs2_val));
      3'b101:  w_cond = ($signed(i_rs1_val) >= $signed(i_rs2_val));
      3'b110:  w_cond = (i_rs1_val <  i_rs2_val);
      3'b111:  w_cond = (i_rs1_val >= i_rs2_val);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_is_jal  = (i_jump == 2'b01);
  assign w_is_jalr = (i_jump == 2'b10);
  assign w_taken   = (i_br_en & w_cond) | w_is_jal | w_is_jalr;

  // Raw target: the jump has priority, which only matters for JALR's base.
  always_comb begin
    w_target = i_ex_pc + i_imm;
    if (w_is_jalr) begin
      w_target = (i_rs1_val + i_imm) & ~XLEN'(1);
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign w_bad        = w_taken & w_target[1];
  assign w_eff_target = w_bad ? TRAP_VECTOR : w_target;
`else
  assign w_bad        = 1'b0;
  assign w_eff_target = w_target & ~XLEN'(3);
`endif

  assign o_link       = i_ex_pc + XLEN'(4);
  assign o_flush      = w_taken;
  assign o_pc         = r_pc;
  assign o_pc_valid   = (r_state != ST_RESET);
  assign o_misalign   = r_misalign;
  assign o_bad_target = r_bad_target;
  assign o_state      = r_state;

  // Next-state and next-PC selection; the youngest redirect always wins.
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_pend_pc_n    = r_pend_pc;
    w_pend_bad_n   = r_pend_bad;
    w_pend_raw_n   = r_pend_raw;
    w_misalign_n   = 1'b0;
    w_bad_target_n = r_bad_target;
    case (r_state)
      ST_RESET: begin
        w_state_n = ST_RUN;
      end
      ST_RUN, ST_PEND: begin
        if (w_taken) begin
          if (i_fetch_ready) begin
            w_pc_n    = w_eff_target;
            w_state_n = ST_RUN;
            if (w_bad) begin
              w_misalign_n   = 1'b1;
              w_bad_target_n = w_target;
            end
          end else begin
            w_pend_pc_n  = w_eff_target;
            w_pend_bad_n = w_bad;
            w_pend_raw_n = w_target;
            w_state_n    = ST_PEND;
          end
        end else if (r_state == ST_PEND) begin
          if (i_fetch_ready) begin
            w_pc_n       = r_pend_pc;
            w_misalign_n = r_pend_bad;
            if (r_pend_bad) begin
              w_bad_target_n = r_pend_raw;
            end
            w_state_n = ST_RUN;
          end
        end else if (i_fetch_ready && !i_stall) begin
          w_pc_n = r_pc + XLEN'(4);
        end
      end
      default: begin
        w_state_n = ST_RESET;
      end
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_pc         <= RESET_VECTOR;
      r_pend_pc    <= '0;
      r_pend_bad   <= 1'b0;
      r_pend_raw   <= '0;
      r_misalign   <= 1'b0;
      r_bad_target <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_pend_pc    <= w_pend_pc_n;
      r_pend_bad   <= w_pend_bad_n;
      r_pend_raw   <= w_pend_raw_n;
      r_misalign   <= w_misalign_n;
      r_bad_target <= w_bad_target_n;
    end
  end

endmodule
